// File: rtl/calc_keypad_scan.sv
// 4x4 matrix-keypad scanner and debouncer feeding calc_top with 4-bit command codes.
// Rows are strobed one-hot-low, columns are synchronised, and one key at a time is debounced per full scan.
module calc_keypad_scan #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_held,
  output logic [1:0] scan_st
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1) + 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Scan-result classes, accumulated across the four rows of one scan.
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  logic [3:0]        col_s1_q, col_s2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        row_q;
  logic              slot_last;
  logic              scan_end;

  logic [3:0]        col_low;
  logic [2:0]        row_hits;
  logic [1:0]        row_col;

  logic [1:0]        acc_res_q, merged_res;
  logic [3:0]        acc_key_q, merged_key;

  state_t            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              lock_q, lock_d;

  logic              is_none, is_single, is_multi, is_cand;

  function automatic logic [3:0] key_to_cmd(input logic [3:0] key);
    logic [3:0] code;
    case (key)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'b1010;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'b1011;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'b1100;
      4'd12:   code = 4'b1110;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'b1111;
      default: code = 4'b1101;
    endcase
    return code;
  endfunction

  // Columns float high; keep the synchroniser at "no key" out of reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  assign slot_last = (slot_q == SLOT_LAST);
  assign scan_end  = slot_last && (row_q == 2'd3);

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_q <= '0;
      row_q  <= 2'd0;
    end else if (slot_last) begin
      slot_q <= '0;
      row_q  <= row_q + 2'd1;
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row_drive
      assign row_n[gi] = (row_q != 2'(gi));
    end
  endgenerate

  assign col_low = ~col_s2_q;

  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (col_low[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  // Fold the current row into the running scan result.
  always_comb begin
    merged_res = acc_res_q;
    merged_key = acc_key_q;
    if (row_hits >= 3'd2) begin
      merged_res = RES_MULTI;
    end else if (row_hits == 3'd1) begin
      if (acc_res_q == RES_NONE) begin
        merged_res = RES_SINGLE;
        merged_key = {row_q, row_col};
      end else begin
        merged_res = RES_MULTI;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_res_q <= RES_NONE;
      acc_key_q <= 4'd0;
    end else if (scan_end) begin
      acc_res_q <= RES_NONE;
      acc_key_q <= 4'd0;
    end else if (slot_last) begin
      acc_res_q <= merged_res;
      acc_key_q <= merged_key;
    end
  end

  assign is_none   = (merged_res == RES_NONE);
  assign is_single = (merged_res == RES_SINGLE);
  assign is_multi  = (merged_res == RES_MULTI);
  assign is_cand   = is_single && (merged_key == cand_q);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      cmd_q       <= 4'd0;
      cmd_valid_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      lock_q      <= lock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    lock_d      = lock_q;
    if (scan_end) begin
      case (state_q)
        ST_IDLE: begin
          // lock_q blocks a key that was already down when the previous release was
          // accepted (no rollover); a single empty scan re-arms the scanner.
          if (is_none) begin
            lock_d = 1'b0;
          end else if (is_single && !lock_q) begin
            state_d = ST_DEBOUNCE;
            cand_d  = merged_key;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (is_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_TARGET) begin
              state_d     = ST_PRESSED;
              cnt_d       = '0;
              cmd_d       = key_to_cmd(cand_q);
              cmd_valid_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (is_none || (is_single && !is_cand)) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        default: begin
          if (is_cand || is_multi) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_TARGET) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              lock_d  = !is_none;
            end
          end
        end
      endcase
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
  assign scan_st   = state_q;

endmodule

// File: tb/tb_calc_keypad_scan.sv
// Directed bench for calc_keypad_scan: keypad matrix model, row stepping, debounce,
// key sequencing, bounce rejection, no-rollover and reset-while-held.
module tb_calc_keypad_scan;

  logic       clock;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       key_held;
  logic [1:0] scan_st;

  logic [15:0] keys;
  int          checks;
  int          errors;
  int          pulse_count;
  logic [3:0]  codes[$];

  calc_keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .key_held  (key_held),
    .scan_st   (scan_st)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (cmd_valid) begin
      pulse_count = pulse_count + 1;
      codes.push_back(cmd);
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input logic [3:0] exp, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (cmd_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 8'(seen), 8'd1);
    if (seen) begin
      check({tag, "_cmd"}, 8'(cmd), 8'(exp));
      tick();
      check({tag, "_one_cycle"}, 8'(cmd_valid), 8'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_n"}, 8'(row_n), 8'h0E);
    check({tag, "_cmd"}, 8'(cmd), 8'd0);
    check({tag, "_valid"}, 8'(cmd_valid), 8'd0);
    check({tag, "_held"}, 8'(key_held), 8'd0);
    check({tag, "_st"}, 8'(scan_st), 8'd0);
  endtask

  initial begin
    int p0;
    bit found;
    logic [3:0] prev;
    logic [3:0] exp_row;
    logic [3:0] exp_codes[5];
    int seq_keys[5];

    checks = 0;
    errors = 0;
    pulse_count = 0;
    keys = 16'h0000;
    reset = 1'b0;

    // 1: reset values and row stepping
    repeat (3) tick();
    check_reset_outputs("t1_reset");
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("t1_row_c%0d", i), 8'(row_n), 8'(exp_row));
      if (i < 20) tick();
    end

    // 2: hold '5', then release
    p0 = pulse_count;
    keys[5] = 1'b1;
    wait_valid("t2_5", 4'd5, 66);
    repeat (60) tick();
    check("t2_single_pulse", 8'(pulse_count - p0), 8'd1);
    check("t2_held", 8'(key_held), 8'd1);
    check("t2_st_pressed", 8'(scan_st), 8'd2);
    keys = 16'h0000;
    repeat (20) tick();
    check("t2_held_after_release", 8'(key_held), 8'd1);
    repeat (60) tick();
    check("t2_released", 8'(key_held), 8'd0);
    check("t2_st_idle", 8'(scan_st), 8'd0);
    check("t2_cmd_kept", 8'(cmd), 8'd5);
    check("t2_total_pulses", 8'(pulse_count - p0), 8'd1);

    // 3: sequence 1,2,C,3,*
    codes.delete();
    seq_keys  = '{0, 1, 11, 2, 12};
    exp_codes = '{4'd1, 4'd2, 4'b1100, 4'd3, 4'b1110};
    for (int s = 0; s < 5; s++) begin
      keys[seq_keys[s]] = 1'b1;
      repeat (80) tick();
      keys = 16'h0000;
      repeat (80) tick();
    end
    check("t3_count", 8'(codes.size()), 8'd5);
    for (int s = 0; s < 5; s++) begin
      if (s < codes.size()) check($sformatf("t3_code%0d", s), 8'(codes[s]), 8'(exp_codes[s]));
    end

    // 4: '7' bouncing, started 10 cycles into a scan
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      prev = row_n;
      tick();
      if (prev == 4'b0111 && row_n == 4'b1110) found = 1'b1;
    end
    check("t4_align", 8'(found), 8'd1);
    repeat (10) tick();
    p0 = pulse_count;
    for (int i = 0; i < 6; i++) begin
      keys[8] = (i % 2 == 0);
      repeat (10) tick();
    end
    keys[8] = 1'b1;
    check("t4_no_pulse_bounce", 8'(pulse_count - p0), 8'd0);
    wait_valid("t4_7", 4'd7, 40);
    check("t4_one_pulse", 8'(pulse_count - p0), 8'd1);
    keys = 16'h0000;
    repeat (80) tick();

    // 5: hold '4', add '9', drop '4', keep '9'
    p0 = pulse_count;
    keys[4] = 1'b1;
    wait_valid("t5_4", 4'd4, 66);
    repeat (20) tick();
    keys[10] = 1'b1;
    repeat (80) tick();
    check("t5_multi_ignored", 8'(pulse_count - p0), 8'd1);
    check("t5_st_pressed", 8'(scan_st), 8'd2);
    keys[4] = 1'b0;
    repeat (80) tick();
    check("t5_st_idle", 8'(scan_st), 8'd0);
    check("t5_held_low", 8'(key_held), 8'd0);
    repeat (80) tick();
    check("t5_no_rollover", 8'(pulse_count - p0), 8'd1);
    check("t5_cmd_still_4", 8'(cmd), 8'd4);
    keys = 16'h0000;
    repeat (40) tick();
    keys[10] = 1'b1;
    wait_valid("t5_9", 4'd9, 66);
    keys = 16'h0000;
    repeat (80) tick();

    // 6: reset while '0' is pressed
    keys[13] = 1'b1;
    wait_valid("t6_0", 4'd0, 66);
    repeat (10) tick();
    check("t6_st_pressed", 8'(scan_st), 8'd2);
    reset = 1'b0;
    tick();
    check_reset_outputs("t6_reset");
    tick();
    reset = 1'b1;
    p0 = pulse_count;
    wait_valid("t6_fresh", 4'd0, 66);
    check("t6_one_fresh_pulse", 8'(pulse_count - p0), 8'd1);
    check("t6_held", 8'(key_held), 8'd1);
    keys = 16'h0000;
    repeat (80) tick();
    check("t6_released", 8'(key_held), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
